// File: rtl/i2c_byte_master_if.sv
// Command, status and open-drain bus signals of the byte-level I2C master.
// The master modport is the engine side; the slave modport is the side
// that issues commands and models the bus lines.
interface i2c_byte_master_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_nack;
  logic          done;
  logic          err;
  logic          ack_rcvd;
  logic [DW-1:0] rdata;
  logic          bus_held;
  logic          scl_i;
  logic          sda_i;
  logic          scl_oe;
  logic          sda_oe;

  modport master (
    input  cmd_valid, cmd, cmd_wdata, cmd_nack, scl_i, sda_i,
    output cmd_ready, done, err, ack_rcvd, rdata, bus_held, scl_oe, sda_oe
  );

  modport slave (
    output cmd_valid, cmd, cmd_wdata, cmd_nack, scl_i, sda_i,
    input  cmd_ready, done, err, ack_rcvd, rdata, bus_held, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master engine. Sequences START / WRITE / READ / STOP
// commands into four quarter-bit phases of CLK_DIV cycles each, honours
// clock stretching whenever SCL is released, and reports completion with a
// one-cycle done pulse. All bus enables are registered so they never glitch.
module i2c_byte_master #(
  parameter int CLK_DIV        = 4,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  i2c_byte_master_if.master bus
);

  localparam int DW = I2C_DATA_WIDTH;
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          samp_q, samp_d;
  logic          rd_q, rd_d;
  logic          nack_q, nack_d;
  logic          ill_q, ill_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          held_q, held_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          stall;
  logic          step;

  // A released SCL still read low means a slave is stretching the clock.
  assign stall = !scl_oe_q && !bus.scl_i;

  // Next-state logic: phase timing, bus-line enables and command results.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    samp_d   = samp_q;
    rd_d     = rd_q;
    nack_d   = nack_q;
    ill_d    = ill_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = err_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    held_d   = held_q;
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    step     = 1'b0;

    // Quarter-bit counter; enables below are set on entry to the next phase.
    if ((state_q == S_START || state_q == S_BIT || state_q == S_ACK ||
         state_q == S_STOP) && !stall) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        ph_d  = ph_q + 2'd1;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        err_d   = 1'b0;
        if (ready_q && bus.cmd_valid) begin
          ready_d = 1'b0;
          ph_d    = 2'd0;
          cnt_d   = '0;
          ill_d   = 1'b0;
          case (bus.cmd)
            CMD_START: begin
              state_d  = S_START;
              sda_oe_d = 1'b0;
            end
            CMD_WRITE, CMD_READ: begin
              if (held_q) begin
                state_d  = S_BIT;
                bit_d    = '0;
                sh_d     = bus.cmd_wdata;
                rd_d     = (bus.cmd == CMD_READ);
                nack_d   = bus.cmd_nack;
                scl_oe_d = 1'b1;
                sda_oe_d = (bus.cmd == CMD_WRITE) & ~bus.cmd_wdata[DW-1];
              end else begin
                // No bus ownership: report an error one cycle later.
                state_d = S_FIN;
                ill_d   = 1'b1;
                cnt_d   = CW'(1);
              end
            end
            default: begin
              if (held_q) begin
                state_d  = S_STOP;
                scl_oe_d = 1'b1;
                sda_oe_d = 1'b1;
              end else begin
                state_d = S_FIN;
                ill_d   = 1'b1;
                cnt_d   = CW'(1);
              end
            end
          endcase
        end
      end

      S_START: begin
        if (step) begin
          case (ph_q)
            2'd0:    scl_oe_d = 1'b0;
            2'd1:    sda_oe_d = 1'b1;
            2'd2:    scl_oe_d = 1'b1;
            default: begin
              state_d = S_FIN;
              held_d  = 1'b1;
            end
          endcase
        end
      end

      S_BIT: begin
        if (step) begin
          case (ph_q)
            2'd0: scl_oe_d = 1'b0;
            2'd2: samp_d   = bus.sda_i;
            2'd3: begin
              scl_oe_d = 1'b1;
              sh_d     = {sh_q[DW-2:0], samp_q};
              if (bit_q == BW'(DW - 1)) begin
                state_d  = S_ACK;
                sda_oe_d = rd_q & ~nack_q;
              end else begin
                bit_d    = bit_q + 1'b1;
                sda_oe_d = ~rd_q & ~sh_q[DW-2];
              end
            end
            default: begin
            end
          endcase
        end
      end

      S_ACK: begin
        if (step) begin
          case (ph_q)
            2'd0: scl_oe_d = 1'b0;
            2'd2: samp_d   = bus.sda_i;
            2'd3: begin
              scl_oe_d = 1'b1;
              state_d  = S_FIN;
              if (rd_q) rdata_d = sh_q;
              else      ack_d   = ~samp_q;
            end
            default: begin
            end
          endcase
        end
      end

      S_STOP: begin
        if (step) begin
          case (ph_q)
            2'd0: scl_oe_d = 1'b0;
            2'd1: sda_oe_d = 1'b0;
            2'd3: begin
              state_d = S_FIN;
              held_d  = 1'b0;
            end
            default: begin
            end
          endcase
        end
      end

      S_FIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done_d  = 1'b1;
          err_d   = ill_q;
          ill_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ph_q     <= 2'd0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      samp_q   <= 1'b0;
      rd_q     <= 1'b0;
      nack_q   <= 1'b0;
      ill_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      held_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      samp_q   <= samp_d;
      rd_q     <= rd_d;
      nack_q   <= nack_d;
      ill_q    <= ill_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      held_q   <= held_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.ack_rcvd  = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.bus_held  = held_q;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;

endmodule
